nn_layer_sequencer: RTL

//  Sequences one fully-connected layer through the shared 64-input dot-product partition (64 FP32 mul + adder tree + bias).
//  For each output neuron: streams 64 weights + 1 bias from weight RAM into a register bank, lets the combinational

---
 rtl/nn_layer_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: drives one fully-connected layer through the shared
// 64-input dot-product partition, one output neuron at a time.
// Optional build macro: RELU_OUT_EN (clamps negative results to +0.0 on write).
module nn_layer_sequencer #(
   parameter int unsigned MAX_NEURONS   = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned ADDR_W        = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                start,
   input  logic [7:0]          num_out,
   input  logic [ADDR_W-1:0]   w_base,
   output logic                busy,
   output logic                done,
   output logic                w_rd_en,
   output logic [ADDR_W-1:0]   w_rd_addr,
   input  logic [31:0]         w_rd_data,
   output logic [2047:0]       W_flat,
   output logic [31:0]         bias,
   input  logic [31:0]         dot_out,
   output logic                res_wr_en,
   output logic [7:0]          res_wr_addr,
   output logic [31:0]         res_wr_data
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned IDX_W    = 7;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned LOAD_LEN = 66;
   localparam int unsigned SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_WRITE,
      ST_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               busy_d, done_d, w_rd_en_d, res_wr_en_d;
   logic [ADDR_W-1:0]  w_rd_addr_d;
   logic [7:0]         res_wr_addr_d;
   logic [DATA_W-1:0]  res_wr_data_d;

   logic [CNT_W-1:0]   clamp_c;
   logic [DATA_W-1:0]  post_c;
   logic [5:0]         slot_c;
   logic [10:0]        lsb_c;

   // Neuron count for a new pass, limited to the largest supported layer
   assign clamp_c = (num_out > CNT_W'(MAX_NEURONS)) ? CNT_W'(MAX_NEURONS) : num_out;

   // Result post-processing applied at write time
`ifdef RELU_OUT_EN
   assign post_c = dot_out[31] ? '0 : dot_out;
`else
   assign post_c = dot_out;
`endif

   // Bank slot fed by the read issued on the previous LOAD cycle
   assign slot_c = 6'(idx_q - IDX_W'(1));
   assign lsb_c  = {slot_c, 5'b0_0000};

   // State and registered-output update
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         set_q       <= '0;
         n_q         <= '0;
         cnt_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         w_rd_en     <= 1'b0;
         w_rd_addr   <= '0;
         res_wr_en   <= 1'b0;
         res_wr_addr <= '0;
         res_wr_data <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         set_q       <= set_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         busy        <= busy_d;
         done        <= done_d;
         w_rd_en     <= w_rd_en_d;
         w_rd_addr   <= w_rd_addr_d;
         res_wr_en   <= res_wr_en_d;
         res_wr_addr <= res_wr_addr_d;
         res_wr_data <= res_wr_data_d;
      end
   end

   // Next-state and next-output logic; outputs are computed for the cycle being entered
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      set_d         = set_q;
      n_d           = n_q;
      cnt_d         = cnt_q;
      busy_d        = busy;
      done_d        = 1'b0;
      w_rd_en_d     = 1'b0;
      w_rd_addr_d   = w_rd_addr;
      res_wr_en_d   = 1'b0;
      res_wr_addr_d = res_wr_addr;
      res_wr_data_d = res_wr_data;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d = clamp_c;
               n_d   = '0;
               idx_d = '0;
               if (clamp_c == '0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_LOAD;
                  busy_d      = 1'b1;
                  w_rd_en_d   = 1'b1;
                  w_rd_addr_d = w_base;
               end
            end
         end
         ST_LOAD: begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(LOAD_LEN - 1)) begin
               state_d = ST_SETTLE;
               idx_d   = '0;
               set_d   = '0;
            end else if (idx_q < IDX_W'(LOAD_LEN - 2)) begin
               w_rd_en_d   = 1'b1;
               w_rd_addr_d = w_rd_addr + ADDR_W'(1);
            end
         end
         ST_SETTLE: begin
            if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d       = ST_WRITE;
               res_wr_en_d   = 1'b1;
               res_wr_addr_d = n_q;
               res_wr_data_d = post_c;
            end else begin
               set_d = set_q + SET_W'(1);
            end
         end
         ST_WRITE: begin
            n_d = n_q + CNT_W'(1);
            if (CNT_W'(n_q + CNT_W'(1)) == cnt_q) begin
               state_d = ST_FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d     = ST_LOAD;
               idx_d       = '0;
               w_rd_en_d   = 1'b1;
               w_rd_addr_d = w_rd_addr + ADDR_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Weight/bias bank: captures returning read data, only while loading
   always_ff @(posedge Clk) begin
      if (Reset) begin
         W_flat <= '0;
         bias   <= '0;
      end else if (state_q == ST_LOAD && idx_q != '0) begin
         if (idx_q == IDX_W'(LOAD_LEN - 1)) begin
            bias <= w_rd_data;
         end else begin
            W_flat[lsb_c +: DATA_W] <= w_rd_data;
         end
      end
   end

endmodule
